load_store_unit: RTL and testbench

Initiator side of the data-memory interface. Accepts one load/store request at a time from the CPU pipeline and drives the data memory's MemRead/MemWrite/address/write_data port. Returns sign- or zero-extended load data and a completion/error pulse. Sub-word stores are performed as read-modify-write, because the memory only writes full 32-bit words.

---
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, sign/zero-extended loads,
// sub-word stores done as read-modify-write because the memory writes whole words.
module load_store_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR} state_t;

  typedef struct packed {
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic [31:0] word_q, word_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;

  logic            accept, req_err;
  logic [3:0][7:0] rd_b, merged;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [31:0]     load_ext;

  assign accept = req_valid & req_ready;

  always_comb begin
    case (req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = req_addr[0];
      3'b010:  req_err = |req_addr[1:0];
      3'b100:  req_err = req_store;
      3'b101:  req_err = req_store | req_addr[0];
      default: req_err = 1'b1;
    endcase
    if (req_addr[31:2] >= 30'(MEM_WORDS)) req_err = 1'b1;
  end

  // Little-endian lane pick from the combinational read data
  always_comb begin
    rd_b = mem_rdata;
    ld_b = rd_b[req_q.addr[1:0]];
    ld_h = req_q.addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (req_q.funct3)
      3'b000:  load_ext = {{24{ld_b[7]}}, ld_b};
      3'b001:  load_ext = {{16{ld_h[15]}}, ld_h};
      3'b100:  load_ext = {24'h0, ld_b};
      3'b101:  load_ext = {16'h0, ld_h};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    merged = word_q;
    if (req_q.funct3[1:0] == 2'b00) begin
      merged[req_q.addr[1:0]] = req_q.wdata[7:0];
    end else begin
      merged[{req_q.addr[1], 1'b0}] = req_q.wdata[7:0];
      merged[{req_q.addr[1], 1'b1}] = req_q.wdata[15:8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      word_q       <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      word_q       <= word_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    word_d       = word_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        req_d.store  = req_store;
        req_d.funct3 = req_funct3;
        req_d.addr   = req_addr;
        req_d.wdata  = req_wdata;
        if (req_err) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_data_d  = '0;
        end else if (!req_store)         state_d = LOAD;
        else if (req_funct3 == 3'b010)   state_d = STORE;
        else                             state_d = RMW_RD;
      end
      LOAD: begin
        resp_valid_d = 1'b1;
        resp_data_d  = load_ext;
        state_d      = IDLE;
      end
      RMW_RD: begin
        word_d  = mem_rdata;
        state_d = RMW_WR;
      end
      STORE, RMW_WR: begin
        resp_valid_d = 1'b1;
        resp_data_d  = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory strobes decode straight from state so reset kills a pending write at once
  always_comb begin
    req_ready = (state_q == IDLE);
    mem_read  = (state_q == LOAD) || (state_q == RMW_RD);
    mem_write = (state_q == STORE) || (state_q == RMW_WR);
    mem_addr  = (state_q == IDLE) ? 32'h0 : {req_q.addr[31:2], 2'b00};
    case (state_q)
      STORE:   mem_wdata = req_q.wdata;
      RMW_WR:  mem_wdata = merged;
      default: mem_wdata = '0;
    endcase
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: driver queues expected responses,
// a negedge monitor pops and compares data, error flag and latency.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
  logic [31:0] resp_data, mem_addr, mem_wdata, mem_rdata;

  load_store_unit #(.MEM_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0, errors = 0, cyc = 0, rd_cnt = 0, wr_cnt = 0;
  logic [31:0] last_waddr = '0, last_wdata = '0;
  logic [31:0] mem [0:255] = '{4: 32'h80FF_7F01, 8: 32'h1122_3344, default: 32'h0};

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mem_read && mem_write) begin
      errors++;
      $display("FAIL rd_wr_overlap: got both high expected exclusive");
    end
    if (mem_read) rd_cnt++;
    if (mem_write) begin
      wr_cnt++;
      last_waddr = mem_addr;
      last_wdata = mem_wdata;
    end
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected 0");
      end else begin
        e = exp_q.pop_front();
        chk("resp_data", resp_data, e.data);
        chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        chk("latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] xd, input logic xe,
                       input int lat);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
    end else begin
      req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
      req_valid = 1'b1;
      exp_q.push_back('{xd, xe, lat, cyc});
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("resp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_resp"}, {resp_data[31:2], resp_valid, resp_err} | resp_data, 32'd0);
    chk({tag, "_mem_strobes"}, {30'b0, mem_read, mem_write}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin : stim
    int r0, w0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("after_reset");

    // Loads from word[4] = 80FF_7F01
    issue(0, 3'b000, 32'h11, 0, 32'h0000_007F, 0, 2); drain();
    issue(0, 3'b000, 32'h13, 0, 32'hFFFF_FF80, 0, 2); drain();
    issue(0, 3'b100, 32'h13, 0, 32'h0000_0080, 0, 2); drain();
    issue(0, 3'b000, 32'h10, 0, 32'h0000_0001, 0, 2); drain();
    issue(0, 3'b100, 32'h12, 0, 32'h0000_00FF, 0, 2); drain();
    issue(0, 3'b001, 32'h12, 0, 32'hFFFF_80FF, 0, 2); drain();
    issue(0, 3'b101, 32'h12, 0, 32'h0000_80FF, 0, 2); drain();
    issue(0, 3'b001, 32'h10, 0, 32'h0000_7F01, 0, 2); drain();

    // Word store then load back
    w0 = wr_cnt;
    issue(1, 3'b010, 32'h20, 32'hDEAD_BEEF, 32'h0, 0, 2); drain();
    chk("sw_write_count", 32'(wr_cnt - w0), 32'd1);
    chk("sw_addr", last_waddr, 32'h20);
    chk("sw_data", last_wdata, 32'hDEAD_BEEF);
    issue(0, 3'b010, 32'h20, 0, 32'hDEAD_BEEF, 0, 2); drain();

    // Sub-word stores on word[8] = 1122_3344
    issue(1, 3'b010, 32'h20, 32'h1122_3344, 32'h0, 0, 2); drain();
    r0 = rd_cnt; w0 = wr_cnt;
    issue(1, 3'b000, 32'h21, 32'h0000_00AB, 32'h0, 0, 3); drain();
    chk("sb_read_count", 32'(rd_cnt - r0), 32'd1);
    chk("sb_write_count", 32'(wr_cnt - w0), 32'd1);
    chk("sb_wdata", last_wdata, 32'h1122_AB44);
    issue(1, 3'b001, 32'h22, 32'h0000_CAFE, 32'h0, 0, 3); drain();
    chk("sh_wdata", last_wdata, 32'hCAFE_AB44);
    issue(0, 3'b010, 32'h20, 0, 32'hCAFE_AB44, 0, 2); drain();

    // Error requests never touch memory
    r0 = rd_cnt; w0 = wr_cnt;
    issue(0, 3'b010, 32'h02,  0, 32'h0, 1, 1); drain();
    issue(0, 3'b001, 32'h01,  0, 32'h0, 1, 1); drain();
    issue(1, 3'b100, 32'h20,  32'h55, 32'h0, 1, 1); drain();
    issue(0, 3'b010, 32'h400, 0, 32'h0, 1, 1); drain();
    issue(0, 3'b011, 32'h20,  0, 32'h0, 1, 1); drain();
    issue(1, 3'b010, 32'h22,  32'h1, 32'h0, 1, 1); drain();
    chk("err_mem_reads", 32'(rd_cnt - r0), 32'd0);
    chk("err_mem_writes", 32'(wr_cnt - w0), 32'd0);

    // Reset while an SB sits in RMW_RD
    @(negedge clk);
    req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h20; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rmw_rd_read", {31'b0, mem_read}, 32'd1);
    w0 = wr_cnt;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_no_write", 32'(wr_cnt - w0), 32'd0);
    chk("rst_word_kept", mem[8], 32'hCAFE_AB44);
    chk_idle_outputs("after_midop_reset");
    issue(0, 3'b010, 32'h20, 0, 32'hCAFE_AB44, 0, 2); drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
